// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage between the PC register and decode. Holds the fetch PC, issues
//   single-outstanding word reads over a req/ack handshake, and buffers returned
//   words with their PC in a small FIFO presented to decode via valid/ready.
//   A redirect flushes the buffer and discards any in-flight read.
//
// Ports
//   clock, reset_n             rising-edge clock, async active-low reset
//   redirect_valid/pc          load new fetch PC (low two bits cleared), flush
//   imem_req/addr              read request (held until ack) and word address
//   imem_ack/rdata             read completion and data
//   inst_valid/ready           FIFO head handshake toward decode
//   inst_data/pc/pc_plus4      head instruction, its PC and link value
//   stall_cycles, flush_count  only with FETCH_STATS_EN defined
//
// Optional feature macro: FETCH_STATS_EN (saturating stall/flush counters).
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INST_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
`ifdef FETCH_STATS_EN
  output logic [ADDR_W-1:0] inst_pc_plus4,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_count
`else
  output logic [ADDR_W-1:0] inst_pc_plus4
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;

  logic [ADDR_W-1:0] mem_pc   [FIFO_DEPTH];
  logic [INST_W-1:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_after;

  logic push;
  logic pop;

  assign pc_plus4 = pc + ADDR_W'(4);

  // Returned data is only kept when it belongs to the current PC stream.
  assign push = (state == S_WAIT) && imem_ack && !redirect_valid;
  assign pop  = inst_valid && inst_ready;

  always_comb begin
    count_after = count + CW'(push) - CW'(pop);
  end

  // Fetch FSM and request interface
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      // An un-acked read cannot be cancelled on the bus; drain it instead.
      case (state)
        S_WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end else begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (count < DEPTH_C) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            pc <= pc_plus4;
            // Back-to-back only while a slot stays reserved for the next word.
            if (count_after < DEPTH_C) begin
              imem_addr <= pc_plus4;
            end else begin
              imem_req <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_after;
    end
  end

  // FIFO storage; contents are only observed through the valid-gated outputs.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_pc[wr_ptr]   <= pc;
      mem_data[wr_ptr] <= imem_rdata;
    end
  end

  assign inst_valid    = (count != '0);
  assign inst_data     = inst_valid ? mem_data[rd_ptr] : '0;
  assign inst_pc       = inst_valid ? mem_pc[rd_ptr] : '0;
  assign inst_pc_plus4 = inst_valid ? (mem_pc[rd_ptr] + ADDR_W'(4)) : '0;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!inst_valid && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (redirect_valid && (flush_count != '1)) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  logic ack_tie;
  logic ack_man;

  int unsigned n_cmp;
  int unsigned n_err;

  // Memory model: zero-wait when tied, otherwise ack driven by hand.
  assign imem_ack   = ack_tie ? imem_req : (ack_man & imem_req);
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  instruction_fetch_unit #(
    .ADDR_W    (32),
    .INST_W    (32),
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
`ifdef FETCH_STATS_EN
    .inst_pc_plus4 (inst_pc_plus4),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`else
    .inst_pc_plus4 (inst_pc_plus4)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the release edge, DUT in IDLE.
  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ack_tie        = 1'b0;
    ack_man        = 1'b0;
    inst_ready     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_req",    {31'd0, imem_req},   32'd0);
    chk("rst_addr",   imem_addr,           32'd0);
    chk("rst_valid",  {31'd0, inst_valid}, 32'd0);
    chk("rst_data",   inst_data,           32'd0);
    chk("rst_pc",     inst_pc,             32'd0);
    chk("rst_pc4",    inst_pc_plus4,       32'd0);
    reset_n = 1'b1;
    tick();
    chk("first_req",  {31'd0, imem_req},   32'd1);
    chk("first_addr", imem_addr,           32'd0);

    // 1: async reset mid-WAIT
    tick();
    reset_n = 1'b0;
    #1;
    chk("t1_req_async",   {31'd0, imem_req},   32'd0);
    chk("t1_valid_async", {31'd0, inst_valid}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("t1_req_after",  {31'd0, imem_req}, 32'd1);
    chk("t1_addr_after", imem_addr,         32'h0000_0000);

    // 2: zero-wait streaming, one instruction per cycle
    ack_tie    = 1'b1;
    inst_ready = 1'b1;
    tick();
    chk("t2_addr4",  imem_addr,           32'h0000_0004);
    chk("t2_valid0", {31'd0, inst_valid}, 32'd1);
    chk("t2_pc0",    inst_pc,             32'h0000_0000);
    chk("t2_data0",  inst_data,           32'hA5A5_0000);
    chk("t2_pc4_0",  inst_pc_plus4,       32'h0000_0004);
    tick();
    chk("t2_addr8",  imem_addr,           32'h0000_0008);
    chk("t2_pc1",    inst_pc,             32'h0000_0004);
    chk("t2_pc4_1",  inst_pc_plus4,       32'h0000_0008);
    tick();
    chk("t2_addrC",  imem_addr,           32'h0000_000C);
    chk("t2_pc2",    inst_pc,             32'h0000_0008);

    // 3: back-pressure fills the buffer, then drains in order
    inst_ready = 1'b0;
    do_reset();
    tick();
    chk("t3_addr0", imem_addr, 32'h0000_0000);
    tick();
    chk("t3_addr4", imem_addr, 32'h0000_0004);
    tick();
    chk("t3_req_full",  {31'd0, imem_req},   32'd0);
    chk("t3_valid",     {31'd0, inst_valid}, 32'd1);
    chk("t3_head0",     inst_pc,             32'h0000_0000);
    tick();
    chk("t3_req_hold",  {31'd0, imem_req},   32'd0);
    chk("t3_head0_hold", inst_pc,            32'h0000_0000);
    inst_ready = 1'b1;
    tick();
    chk("t3_head1",     inst_pc,             32'h0000_0004);
    chk("t3_data1",     inst_data,           32'hA5A5_0004);
    chk("t3_req_pop",   {31'd0, imem_req},   32'd0);
    tick();
    chk("t3_req_next",  {31'd0, imem_req},   32'd1);
    chk("t3_addr_next", imem_addr,           32'h0000_0008);
    chk("t3_empty",     {31'd0, inst_valid}, 32'd0);

    // 4: redirect in cycle 2 of a 3-cycle read at 0x8
    ack_tie    = 1'b1;
    inst_ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    chk("t4_addr8", imem_addr, 32'h0000_0008);
    ack_tie = 1'b0;
    ack_man = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    chk("t4_drain_req",  {31'd0, imem_req},   32'd1);
    chk("t4_drain_addr", imem_addr,           32'h0000_0008);
    chk("t4_flushed",    {31'd0, inst_valid}, 32'd0);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("t4_req_off",   {31'd0, imem_req},   32'd0);
    chk("t4_discarded", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t4_req40",  {31'd0, imem_req}, 32'd1);
    chk("t4_addr40", imem_addr,         32'h0000_0040);

    // 5: unaligned redirect coincident with ack
    ack_man        = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    tick();
    redirect_valid = 1'b0;
    ack_man        = 1'b0;
    chk("t5_req_idle", {31'd0, imem_req},   32'd0);
    chk("t5_dropped",  {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t5_req",  {31'd0, imem_req}, 32'd1);
    chk("t5_addr", imem_addr,         32'h0000_0040);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("t5_head_pc",   inst_pc,   32'h0000_0040);
    chk("t5_head_data", inst_data, 32'hA5A5_0040);
    chk("t5_addr44",    imem_addr, 32'h0000_0044);

    // 6: PC wraps from 0xFFFFFFFC to 0
    ack_tie = 1'b0;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    ack_tie        = 1'b1;
    tick();
    chk("t6_req_idle", {31'd0, imem_req}, 32'd0);
    tick();
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_addr_wrap", imem_addr,     32'h0000_0000);
    chk("t6_head_pc",   inst_pc,       32'hFFFF_FFFC);
    chk("t6_head_data", inst_data,     32'h5A5A_FFFC);
    chk("t6_link_wrap", inst_pc_plus4, 32'h0000_0000);
`ifdef FETCH_STATS_EN
    chk("t6_flush_count", {16'd0, flush_count}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
